// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types for the multicore shared-memory port: opcodes, arbiter states
// and the grant-index width helper.
package shared_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_STORE = 2'd1,
        OP_ADD   = 2'd2,
        OP_SUB   = 2'd3
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int MAX_CORES = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Core-side request/completion bundle for the shared-memory port.
interface shared_mem_arbiter_if #(
    parameter int NUM_CORES = 3,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int RES_W     = 16
);
    import shared_mem_arbiter_pkg::*;

    localparam int IW = idx_w(NUM_CORES);

    logic [NUM_CORES-1:0] start_op;
    opcode_t              op_sel     [NUM_CORES];
    logic [ADDR_W-1:0]    address_in [NUM_CORES];
    logic [DATA_W-1:0]    data_in    [NUM_CORES];
    logic [NUM_CORES-1:0] end_op;
    logic [RES_W-1:0]     result     [NUM_CORES];
    logic [NUM_CORES-1:0] op_err;
    logic                 busy;
    logic [IW-1:0]        grant_id;

    modport master (
        output start_op, op_sel, address_in, data_in,
        input  end_op, result, op_err, busy, grant_id
    );

    modport slave (
        input  start_op, op_sel, address_in, data_in,
        output end_op, result, op_err, busy, grant_id
    );

endinterface

// File: rtl/shared_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter  int NUM_CORES = 3,
    localparam int IW        = idx_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_CORES-1:0] gnt,
    output logic [IW-1:0]        idx,
    output logic                 any_req
);

    // scan farthest-first so the requester nearest to ptr is written last and wins
    always_comb begin
        int   pos;
        logic hit;
        pos     = 0;
        hit     = 1'b0;
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int off = NUM_CORES - 1; off >= 0; off--) begin
            pos     = (int'(ptr) + off) % NUM_CORES;
            hit     = req[pos];
            gnt     = hit ? (NUM_CORES'(1) << pos) : gnt;
            idx     = hit ? IW'(pos) : idx;
            any_req = any_req | hit;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shared single-ported data memory serving N cores one request at a time,
// round-robin, with edge-qualified requests and error completion.
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 3,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4096,
    parameter int RES_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_mem_arbiter_if.slave  bus
);

    localparam int IW = idx_w(NUM_CORES);
    localparam int MW = idx_w(DEPTH);

    arb_state_t           state_q, state_d;
    logic [NUM_CORES-1:0] pending_q, pending_d, start_op_q, rise_s, gnt_s;
    logic [NUM_CORES-1:0] end_op_q, end_op_d, op_err_q, op_err_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d, ch_q, ch_d, gidx_s;
    logic                 any_req_s, addr_ok_s;
    opcode_t              op_q, op_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d, rdata_q;
    logic                 err_q, err_d, load_ok_q, load_ok_d, busy_q, busy_d;
    logic [RES_W-1:0]     result_q [NUM_CORES];
    logic [RES_W-1:0]     result_d [NUM_CORES];
    logic [DATA_W-1:0]    mem [DEPTH];

    assign rise_s    = bus.start_op & ~start_op_q;
    assign addr_ok_s = (64'(addr_q) < 64'(DEPTH));

    rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr_arbiter (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .gnt     (gnt_s),
        .idx     (gidx_s),
        .any_req (any_req_s)
    );

    // next-state, request bookkeeping and completion outputs
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rr_ptr_d  = rr_ptr_q;
        ch_d      = ch_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        load_ok_d = load_ok_q;
        end_op_d  = '0;
        op_err_d  = '0;
        result_d  = result_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    ch_d = gidx_s;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        op_d   = gnt_s[i] ? bus.op_sel[i]     : op_d;
                        addr_d = gnt_s[i] ? bus.address_in[i] : addr_d;
                        data_d = gnt_s[i] ? bus.data_in[i]    : data_d;
                    end
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                err_d     = !(addr_ok_s && (op_q == OP_LOAD || op_q == OP_STORE));
                load_ok_d = addr_ok_s && (op_q == OP_LOAD);
                state_d   = DONE;
            end
            DONE: begin
                end_op_d[ch_q] = 1'b1;
                op_err_d[ch_q] = err_q;
                if (load_ok_q) begin
                    result_d[ch_q] = RES_W'(rdata_q);
                end else begin
                    result_d[ch_q] = result_q[ch_q];
                end
                pending_d[ch_q] = 1'b0;
                rr_ptr_d = (ch_q == IW'(NUM_CORES - 1)) ? '0 : ch_q + IW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a fresh edge in the DONE cycle must survive the clear above
        pending_d = pending_d | rise_s;
        busy_d    = (state_d != IDLE);
    end

    // control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            start_op_q <= '0;
            rr_ptr_q   <= '0;
            ch_q       <= '0;
            op_q       <= OP_LOAD;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            load_ok_q  <= 1'b0;
            end_op_q   <= '0;
            op_err_q   <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) result_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            start_op_q <= bus.start_op;
            rr_ptr_q   <= rr_ptr_d;
            ch_q       <= ch_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            load_ok_q  <= load_ok_d;
            end_op_q   <= end_op_d;
            op_err_q   <= op_err_d;
            busy_q     <= busy_d;
            for (int i = 0; i < NUM_CORES; i++) result_q[i] <= result_d[i];
        end
    end

    // memory port: contents survive reset, but a reset edge in ACCESS blocks the write
    always_ff @(posedge clk) begin
        if (rst && state_q == ACCESS && addr_ok_s && op_q == OP_STORE) begin
            mem[addr_q[MW-1:0]] <= data_q;
        end
        if (state_q == ACCESS && addr_ok_s && op_q == OP_LOAD) begin
            rdata_q <= mem[addr_q[MW-1:0]];
        end
    end

    assign bus.end_op   = end_op_q;
    assign bus.op_err   = op_err_q;
    assign bus.result   = result_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = ch_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Bench for shared_mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_shared_mem_arbiter;
    import shared_mem_arbiter_pkg::*;

    localparam int N = 3, AW = 13, DW = 8, DEPTH = 4096, RW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shared_mem_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .RES_W(RW)) bus ();

    shared_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RES_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: pending set, round-robin pointer, one op in flight with a
    // 3-edge life (grant, memory access, completion).
    bit [N-1:0]  m_pend, m_prev, m_end, m_err;
    bit          m_busy, m_bad, m_ldok;
    int          m_rr, m_ch, m_phase, m_addr;
    opcode_t     m_op;
    logic [7:0]  m_data, m_ld;
    logic [15:0] m_res [N];
    logic [7:0]  mm [DEPTH];

    task automatic model_step();
        int j;
        bit ok, found;
        if (!rst) begin
            m_pend = '0; m_prev = '0; m_end = '0; m_err = '0;
            m_rr = 0; m_ch = 0; m_busy = 1'b0; m_phase = 0;
            for (int i = 0; i < N; i++) m_res[i] = 16'h0000;
        end else begin
            m_end = '0;
            m_err = '0;
            if (m_busy) begin
                m_phase++;
                if (m_phase == 1) begin
                    ok = (m_addr < DEPTH);
                    if (ok && m_op == OP_STORE) mm[m_addr] = m_data;
                    if (ok && m_op == OP_LOAD) m_ld = mm[m_addr];
                    m_bad  = !(ok && (m_op == OP_LOAD || m_op == OP_STORE));
                    m_ldok = ok && (m_op == OP_LOAD);
                end else begin
                    m_end[m_ch] = 1'b1;
                    m_err[m_ch] = m_bad;
                    if (m_ldok) m_res[m_ch] = {8'h00, m_ld};
                    m_pend[m_ch] = 1'b0;
                    m_rr   = (m_ch + 1) % N;
                    m_busy = 1'b0;
                end
            end else if (m_pend != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (!found && m_pend[j]) begin
                        found = 1'b1;
                        m_ch  = j;
                    end
                end
                m_op    = bus.op_sel[m_ch];
                m_addr  = int'(bus.address_in[m_ch]);
                m_data  = bus.data_in[m_ch];
                m_busy  = 1'b1;
                m_phase = 0;
            end
            m_pend = m_pend | (bus.start_op & ~m_prev);
            m_prev = bus.start_op;
        end
    endtask

    task automatic compare_step();
        check("end_op", 32'(bus.end_op), 32'(m_end));
        check("op_err", 32'(bus.op_err), 32'(m_err));
        check("busy", 32'(bus.busy), 32'(m_busy));
        if (m_busy) check("grant_id", 32'(bus.grant_id), 32'(m_ch));
        for (int i = 0; i < N; i++) check($sformatf("result[%0d]", i), 32'(bus.result[i]), 32'(m_res[i]));
        check("end_op_onehot", 32'($countones(bus.end_op) <= 1), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) compare_step();
    end

    task automatic set_req(input int ch, input opcode_t op, input int addr, input int data);
        bus.op_sel[ch]     = op;
        bus.address_in[ch] = AW'(addr);
        bus.data_in[ch]    = DW'(data);
        bus.start_op[ch]   = 1'b1;
    endtask

    // lat counts negedges after the request edge until end_op is seen (4 = end_op after edge k+3)
    task automatic run_op(input int ch, input opcode_t op, input int addr, input int data,
                          output int lat, output logic err, output logic [15:0] res);
        @(negedge clk);
        set_req(ch, op, addr, data);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.end_op[ch] && lat < 20);
        err = bus.op_err[ch];
        res = bus.result[ch];
        bus.start_op[ch] = 1'b0;
    endtask

    // two cores raise together; returns which one completes first
    task automatic pair(input int a, input int b, output int first);
        @(negedge clk);
        set_req(a, OP_LOAD, 1, 0);
        set_req(b, OP_LOAD, 3, 0);
        first = -1;
        repeat (14) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (first < 0 && bus.end_op[i]) first = i;
        end
        bus.start_op[a] = 1'b0;
        bus.start_op[b] = 1'b0;
    endtask

    initial begin
        int lat, first, cnt;
        logic err;
        logic [15:0] res;
        int ord[$];
        int tim[$];
        bit [N-1:0] outst;
        opcode_t rop;
        int raddr;

        bus.start_op = '0;
        for (int i = 0; i < N; i++) begin
            bus.op_sel[i] = OP_LOAD;
            bus.address_in[i] = '0;
            bus.data_in[i] = '0;
        end
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_end_op", 32'(bus.end_op), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_result0", 32'(bus.result[0]), 32'd0);
        rst = 1'b1;

        // preload addresses 0..63 with (a*7+3) mod 256
        for (int a = 0; a < 64; a++) begin
            run_op(0, OP_STORE, a, (a * 7 + 3) & 255, lat, err, res);
            check("init_lat", 32'(lat), 32'd4);
        end

        run_op(0, OP_STORE, 12'h011, 8'hFE, lat, err, res);
        check("st_lat", 32'(lat), 32'd4);
        check("st_err", 32'(err), 32'd0);
        run_op(0, OP_LOAD, 12'h011, 0, lat, err, res);
        check("ld_lat", 32'(lat), 32'd4);
        check("ld_err", 32'(err), 32'd0);
        check("ld_res", 32'(res), 32'h00FE);

        // core2 op leaves the pointer at 0, then all three request together
        run_op(2, OP_LOAD, 1, 0, lat, err, res);
        @(negedge clk);
        set_req(0, OP_STORE, 1, 8'h11);
        set_req(1, OP_STORE, 2, 8'h22);
        set_req(2, OP_STORE, 3, 8'h33);
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (bus.end_op[i]) begin ord.push_back(i); tim.push_back(t); end
        end
        bus.start_op = '0;
        check("rr3_count", 32'(ord.size()), 32'd3);
        if (ord.size() == 3) begin
            check("rr3_ord0", 32'(ord[0]), 32'd0);
            check("rr3_ord1", 32'(ord[1]), 32'd1);
            check("rr3_ord2", 32'(ord[2]), 32'd2);
            check("rr3_t0", 32'(tim[0]), 32'd4);
            check("rr3_gap1", 32'(tim[1] - tim[0]), 32'd3);
            check("rr3_gap2", 32'(tim[2] - tim[1]), 32'd3);
        end
        run_op(0, OP_LOAD, 1, 0, lat, err, res);
        check("rb_0x001", 32'(res), 32'h0011);
        run_op(1, OP_LOAD, 2, 0, lat, err, res);
        check("rb_0x002", 32'(res), 32'h0022);
        run_op(2, OP_LOAD, 3, 0, lat, err, res);
        check("rb_0x003", 32'(res), 32'h0033);

        pair(0, 2, first);
        check("pair_wrap_first", 32'(first), 32'd0);
        run_op(0, OP_LOAD, 1, 0, lat, err, res);
        pair(0, 2, first);
        check("pair_after0_first", 32'(first), 32'd2);

        // held-high strobe raises only one request
        @(negedge clk);
        set_req(1, OP_LOAD, 5, 0);
        cnt = 0;
        repeat (10) begin @(negedge clk); if (bus.end_op[1]) cnt++; end
        check("hold_pulses", 32'(cnt), 32'd1);
        check("hold_res", 32'(bus.result[1]), 32'h0026);
        bus.start_op[1] = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.end_op[1]) cnt++; end
        bus.start_op[1] = 1'b1;
        repeat (6) begin @(negedge clk); if (bus.end_op[1]) cnt++; end
        bus.start_op[1] = 1'b0;
        check("rehold_pulses", 32'(cnt), 32'd2);

        run_op(0, OP_ADD, 5, 0, lat, err, res);
        check("add_err", 32'(err), 32'd1);
        check("add_res", 32'(res), 32'h0011);
        run_op(1, OP_LOAD, 4096, 0, lat, err, res);
        check("oob_ld_err", 32'(err), 32'd1);
        check("oob_ld_res", 32'(res), 32'h0026);
        run_op(0, OP_STORE, 4096, 8'h55, lat, err, res);
        check("oob_st_err", 32'(err), 32'd1);
        run_op(0, OP_LOAD, 0, 0, lat, err, res);
        check("oob_no_alias", 32'(res), 32'h0003);

        // reset while the store is in ACCESS
        @(negedge clk);
        set_req(0, OP_STORE, 12'h020, 8'hAA);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        bus.start_op = '0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_end", 32'(bus.end_op), 32'd0);
        check("mid_rst_res0", 32'(bus.result[0]), 32'd0);
        rst = 1'b1;
        repeat (3) begin @(negedge clk); check("post_rst_end", 32'(bus.end_op), 32'd0); end
        run_op(0, OP_LOAD, 12'h020, 0, lat, err, res);
        check("rst_store_dropped", 32'(res), 32'h00E3);
        check("rst_ld_lat", 32'(lat), 32'd4);

        // random traffic; operands held stable while a request is outstanding
        outst = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (m_end[i]) outst[i] = 1'b0;
                if (outst[i]) begin
                    if ($urandom_range(0, 3) == 0) bus.start_op[i] = 1'b0;
                end else if (bus.start_op[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.start_op[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    rop   = opcode_t'($urandom_range(0, 3));
                    raddr = ($urandom_range(0, 9) == 0) ? 4096 + int'($urandom_range(0, 4095))
                                                        : int'($urandom_range(0, 63));
                    set_req(i, rop, raddr, int'($urandom_range(0, 255)));
                    outst[i] = 1'b1;
                end
            end
        end
        bus.start_op = '0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
